// File: rtl/pipe_stage_buf_pkg.sv
// Shared EX->MEM stage types: default widths and the packed stage payload.
package pipe_pkg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 10;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   dat2;
    logic [XLEN:0]     alu;
    logic [RD_W-1:0]   rd;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);
endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream handshake bundle of the EX->MEM stage buffer.
// Handshake: a beat moves on a rising edge where valid && ready; valid never waits on ready.
interface pipe_stage_buf_if
  import pipe_pkg::*;
#(
  parameter int P_XLEN   = XLEN,
  parameter int P_CTRL_W = CTRL_W,
  parameter int P_RD_W   = RD_W
);
  logic                in_valid;
  logic                in_ready;
  logic [P_CTRL_W-1:0] in_ctrl;
  logic [P_XLEN-1:0]   in_pc;
  logic [P_XLEN-1:0]   in_dat2;
  logic [P_XLEN:0]     in_alu;
  logic [P_RD_W-1:0]   in_rd;

  logic                out_valid;
  logic                out_ready;
  logic [P_CTRL_W-1:0] out_ctrl;
  logic [P_XLEN-1:0]   out_pc;
  logic [P_XLEN-1:0]   out_dat2;
  logic [P_XLEN:0]     out_alu;
  logic [P_RD_W-1:0]   out_rd;

  modport master (
    output in_valid, in_ctrl, in_pc, in_dat2, in_alu, in_rd, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_dat2, out_alu, out_rd
  );

  modport slave (
    input  in_valid, in_ctrl, in_pc, in_dat2, in_alu, in_rd, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_dat2, out_alu, out_rd
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Payload-agnostic valid/ready register; PIPE_SKID_EN adds a skid slot so in_ready is registered.
// Empty slots always hold an all-zero payload.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_valid;
  logic [W-1:0] main_data;

  assign out_valid = main_valid;
  assign out_data  = main_data;

`ifdef PIPE_SKID_EN
  logic         skid_valid;
  logic [W-1:0] skid_data;

  // No out_ready term: backpressure reaches upstream one cycle late, the skid slot absorbs it.
  assign in_ready = flush || !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else begin
        main_valid <= in_valid;
        main_data  <= in_valid ? in_data : '0;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready = flush || !main_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
    end else if (!main_valid || out_ready) begin
      main_valid <= in_valid;
      main_data  <= in_valid ? in_data : '0;
    end
  end
`endif
endmodule

// File: rtl/pipe_stage_buf.sv
// EX->MEM pipeline stage register with flush and saturating stall counter.
// Build with PIPE_SKID_EN defined for a two-deep skid buffer with registered in_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int RD_W   = pipe_pkg::RD_W,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  pipe_stage_buf_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cnt
);
  // Same field order as ex_mem_t, sized by this instance's parameters.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   dat2;
    logic [XLEN:0]     alu;
    logic [RD_W-1:0]   rd;
  } stage_t;

  localparam int W = $bits(stage_t);

  stage_t in_data;
  stage_t out_data;

  assign in_data.ctrl = bus.in_ctrl;
  assign in_data.pc   = bus.in_pc;
  assign in_data.dat2 = bus.in_dat2;
  assign in_data.alu  = bus.in_alu;
  assign in_data.rd   = bus.in_rd;

  pipe_skid_reg #(.W(W)) u_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_data)
  );

  assign bus.out_ctrl = out_data.ctrl;
  assign bus.out_pc   = out_data.pc;
  assign bus.out_dat2 = out_data.dat2;
  assign bus.out_alu  = out_data.alu;
  assign bus.out_rd   = out_data.rd;

  // Flush deliberately leaves the counter alone; it measures downstream pressure, not beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule
